// File: rtl/scan_chain_host.sv
// scan_chain_host
//
// Purpose: host-side controller for a processor scan chain.
// One "exchange" shifts CHAIN_LEN bits through the chain. Bits to load come
// in a byte stream, and bits captured from the chain go out in a byte stream.
// Both streams are LSB-first: stream bit n is the nth bit shifted.
// The chain only advances while a byte is actually shifting. A stall on
// either stream therefore freezes the chain in place.
//
// Parameters:
//   CHAIN_LEN    total scan chain length in bits (1..65535)
//
// Ports:
//   clk          single clock shared with the processor
//   rst          synchronous active-high reset
//   start        request one full chain exchange (only honoured in IDLE)
//   run          host request to let the processor execute
//   in_data      byte to shift into the chain
//   in_valid     in_data is valid
//   in_ready     controller is ready to accept a byte
//   out_data     byte captured from the chain
//   out_valid    out_data is valid
//   out_ready    consumer accepts out_data
//   busy         exchange in progress (state is not IDLE)
//   done         one-cycle pulse when an exchange completes
//   scan_enable  to the processor's scan_enable
//   scan_out     to the processor's scan_in
//   scan_in      from the processor's scan_out
//   proc_en      to the processor's proc_en (combinational)

module scan_chain_host #(
  parameter int CHAIN_LEN = 2096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       scan_enable,
  output logic       scan_out,
  input  logic       scan_in,
  output logic       proc_en
);

  // 16 bits is enough to hold CHAIN_LEN itself (max 65535).
  // The counter therefore reaches the final value without wrapping.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TOTAL_BITS = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    EMIT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       tx;
  logic [7:0]       rx;
  logic [2:0]       bit_idx;
  logic             shift_last;
  logic             chain_done;

  // Every byte starts on a multiple of 8.
  // The low counter bits are therefore the bit position inside the current byte.
  assign bit_idx = bit_cnt[2:0];

  // A byte ends after its 8th bit or at the last chain bit, whichever comes first.
  // This gives the short final byte when CHAIN_LEN is not a multiple of 8.
  assign shift_last = (bit_idx == 3'd7) || (bit_cnt == LAST_BIT);

  assign chain_done = (bit_cnt == TOTAL_BITS);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode.
  // scan_enable is asserted only in SHIFT, so a stall never moves the chain.
  // in_ready (LOAD) and out_valid (EMIT) come from different states and can
  // never be high together.
  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    scan_enable = 1'b0;
    scan_out    = 1'b0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        scan_enable = 1'b1;
        scan_out    = tx[0];
        if (shift_last) begin
          state_next = EMIT;
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = chain_done ? DONE : LOAD;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: TX shift register, RX capture register and the chain bit counter.
  // RX is cleared when each byte is loaded. Bits past the end of a short final
  // byte therefore read back as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        if (start) begin
          bit_cnt <= '0;
        end
      end else if (state == LOAD) begin
        if (in_valid) begin
          tx <= in_data;
          rx <= '0;
        end
      end else if (state == SHIFT) begin
        tx          <= {1'b0, tx[7:1]};
        rx[bit_idx] <= scan_in;
        bit_cnt     <= bit_cnt + CNT_W'(1);
      end
    end
  end

  assign out_data = rx;
  assign busy     = (state != IDLE);

  // The processor must not run during an exchange.
  // Gating on start as well keeps it halted on the very cycle an exchange is requested.
  assign proc_en  = run & (state == IDLE) & ~start;

endmodule

// File: tb/tb_scan_chain_host.sv
// tb_scan_chain_host
//
// Purpose: self-checking bench for scan_chain_host with a 12-bit chain.
// A processor scan chain is modelled as a plain shift register that advances
// whenever scan_enable is high.
// Expected stream bytes and the final chain contents come from the stream rule:
//   - output stream bit n is the nth original chain bit;
//   - after an exchange, chain bit n holds input stream bit n.
//
// Ports: none (top-level bench).

module tb_scan_chain_host;

  localparam int L = 12;

  logic       clk;
  logic       rst;
  logic       start;
  logic       run;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       scan_enable;
  logic       scan_out;
  logic       scan_in;
  logic       proc_en;

  int n_cmp = 0;
  int n_bad = 0;

  logic [L-1:0] chain;
  logic [L-1:0] preload_val;
  logic         preload_en;
  logic         mon_clr;
  int           se_cnt;
  int           done_cnt;

  typedef struct {
    logic [L-1:0] init;
    logic [7:0]   b0;
    logic [7:0]   b1;
    logic [7:0]   e0;
    logic [7:0]   e1;
    logic [L-1:0] efin;
  } vec_t;

  vec_t vecs [4];

  scan_chain_host #(
    .CHAIN_LEN(L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .run        (run),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .scan_enable(scan_enable),
    .scan_out   (scan_out),
    .scan_in    (scan_in),
    .proc_en    (proc_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor chain model, plus counters for scan_enable cycles and done pulses.
  always @(posedge clk) begin
    if (preload_en) begin
      chain <= preload_val;
    end else if (scan_enable) begin
      chain <= {scan_out, chain[L-1:1]};
    end
    if (mon_clr) begin
      se_cnt   <= 0;
      done_cnt <= 0;
    end else begin
      if (scan_enable) se_cnt <= se_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  assign scan_in = chain[0];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic iv,
                               input logic [7:0] id, input logic ordy);
    start     = s;
    run       = r;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: output byte idx holds original chain bits 8*idx.., zero past the end.
  function automatic logic [7:0] expOutByte(input logic [L-1:0] init, input int idx);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (idx * 8 + k < L) r[k] = init[idx * 8 + k];
    end
    return r;
  endfunction

  // Reference: chain bit n ends up holding input stream bit n.
  function automatic logic [L-1:0] expFinal(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0]  s;
    logic [L-1:0] f;
    s = {b1, b0};
    f = '0;
    for (int n = 0; n < L; n++) f[n] = s[n];
    return f;
  endfunction

  task automatic preloadChain(input logic [L-1:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    mon_clr     = 1'b1;
    tick();
    preload_en  = 1'b0;
    mon_clr     = 1'b0;
  endtask

  // Runs a full 12-bit exchange, with optional stalls on each stream.
  // If mid_start is set, a spurious start is also issued during the exchange.
  task automatic doExchange(input logic [L-1:0] init, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] e0,
                            input logic [7:0] e1, input logic [L-1:0] efin,
                            input int in_stall, input int out_stall,
                            input bit mid_start);
    logic [7:0]   bytes [2];
    logic [7:0]   exp [2];
    logic [7:0]   held;
    logic [L-1:0] snap;
    int           waited;
    bytes[0] = b0;
    bytes[1] = b1;
    exp[0]   = e0;
    exp[1]   = e1;
    preloadChain(init);
    start = 1'b1;
    #1;
    checkOutput("proc_en_start_cycle", proc_en, 0);
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    for (int i = 0; i < 2; i++) begin
      waited = 0;
      while (!in_ready && waited < 40) begin
        tick();
        waited++;
      end
      checkOutput("in_ready_reached", in_ready, 1);
      for (int s = 0; s < in_stall; s++) begin
        if (mid_start && s == 0) start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("starve_in_ready", in_ready, 1);
        checkOutput("starve_scan_enable", scan_enable, 0);
        checkOutput("starve_busy", busy, 1);
        checkOutput("starve_proc_en", proc_en, 0);
      end
      in_valid = 1'b1;
      in_data  = bytes[i];
      tick();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      checkOutput("shift_scan_enable", scan_enable, 1);
      waited = 0;
      while (!out_valid && waited < 40) begin
        tick();
        waited++;
      end
      checkOutput("out_valid_reached", out_valid, 1);
      held = out_data;
      snap = chain;
      for (int s = 0; s < out_stall; s++) begin
        tick();
        checkOutput("bp_out_data_stable", out_data, held);
        checkOutput("bp_out_valid", out_valid, 1);
        checkOutput("bp_scan_enable", scan_enable, 0);
        checkOutput("bp_in_ready", in_ready, 0);
        checkOutput("bp_chain_frozen", chain, snap);
      end
      checkOutput(i == 0 ? "out_byte0" : "out_byte1", out_data, exp[i]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    checkOutput("done_pulse", done, 1);
    checkOutput("proc_en_done_cycle", proc_en, 0);
    tick();
    checkOutput("done_cleared", done, 0);
    checkOutput("busy_cleared", busy, 0);
    checkOutput("proc_en_after_done", proc_en, run);
    checkOutput("scan_enable_cycles", se_cnt, L);
    checkOutput("done_pulse_count", done_cnt, 1);
    checkOutput("chain_final", chain, efin);
  endtask

  initial begin
    logic [L-1:0] ri;
    logic [7:0]   rb0;
    logic [7:0]   rb1;

    vecs[0] = '{12'hABC, 8'h5A, 8'h03, 8'hBC, 8'h0A, 12'h35A};
    vecs[1] = '{12'h000, 8'hFF, 8'hFF, 8'h00, 8'h00, 12'hFFF};
    vecs[2] = '{12'hFFF, 8'h00, 8'hF0, 8'hFF, 8'h0F, 12'h000};
    vecs[3] = '{12'h123, 8'h45, 8'h67, 8'h23, 8'h01, 12'h745};

    preload_en  = 1'b0;
    preload_val = '0;
    mon_clr     = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset for two cycles with run low.
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_scan_enable", scan_enable, 0);
    checkOutput("rst_scan_out", scan_out, 0);
    checkOutput("rst_proc_en", proc_en, 0);
    checkOutput("rst_out_data", out_data, 0);

    // Reset wins over start.
    start = 1'b1;
    tick();
    checkOutput("rst_over_start_busy", busy, 0);
    start = 1'b0;
    rst   = 1'b0;
    tick();

    // Idle gating.
    run = 1'b1;
    #1;
    checkOutput("proc_en_idle_run", proc_en, 1);

    // Table vectors; vector 0 also starves input for 7 cycles and
    // holds out_ready low for 5 cycles on each byte.
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      doExchange(vecs[i].init, vecs[i].b0, vecs[i].b1, vecs[i].e0,
                 vecs[i].e1, vecs[i].efin, (i == 0) ? 7 : 0,
                 (i == 0) ? 5 : 0, 1'b0);
    end

    // Gating with a second start issued mid-exchange.
    run = 1'b1;
    doExchange(12'hABC, 8'h5A, 8'h03, 8'hBC, 8'h0A, 12'h35A, 2, 1, 1'b1);

    // Reset on the 3rd SHIFT cycle aborts without a done pulse.
    run = 1'b0;
    preloadChain(12'h5C3);
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checkOutput("midrst_shift3_scan_enable", scan_enable, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_scan_enable", scan_enable, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_data", out_data, 0);
    tick();
    tick();
    checkOutput("midrst_no_done", done_cnt, 0);
    doExchange(12'h5C3, 8'h3C, 8'h09, expOutByte(12'h5C3, 0),
               expOutByte(12'h5C3, 1), expFinal(8'h3C, 8'h09), 0, 0, 1'b0);

    // Randomised exchanges against the stream-rule reference.
    for (int t = 0; t < 16; t++) begin
      ri  = L'($urandom);
      rb0 = 8'($urandom);
      rb1 = 8'($urandom);
      run = 1'($urandom_range(0, 1));
      doExchange(ri, rb0, rb1, expOutByte(ri, 0), expOutByte(ri, 1),
                 expFinal(rb0, rb1), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scan_chain_host.md
SCAN_CHAIN_HOST -- requirements
Module: scan_chain_host

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 2096, meaning the total scan chain length in bits (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock shared with the processor.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request one full chain exchange.
REQ-005 SHALL have port run, input, 1 bit: host request to let the processor execute.
REQ-006 SHALL have ports in_data (input, 8 bits), in_valid (input, 1 bit) and in_ready (output, 1 bit): the byte stream to shift into the chain.
REQ-007 SHALL have ports out_data (output, 8 bits), out_valid (output, 1 bit) and out_ready (input, 1 bit): the byte stream of bits captured from the chain.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when an exchange completes.
REQ-010 SHALL have port scan_enable, output, 1 bit: drives the processor's scan_enable.
REQ-011 SHALL have port scan_out, output, 1 bit: drives the processor's scan_in.
REQ-012 SHALL have port scan_in, input, 1 bit: driven by the processor's scan_out.
REQ-013 SHALL have port proc_en, output, 1 bit: drives the processor's proc_en.

Function
REQ-014 SHALL implement the states IDLE, LOAD, SHIFT, EMIT and DONE.
REQ-015 IDLE: on start=1, SHALL go to LOAD and clear the bit counter; start SHALL be ignored in every other state.
REQ-016 LOAD: in_ready=1; on in_valid&in_ready, SHALL latch in_data into the TX register, clear the RX register, and go to SHIFT.
REQ-017 SHIFT: scan_enable=1, scan_out=TX[0], and each cycle TX shifts right; scan_in is sampled the same cycle into RX[k], where k is the bit index within the byte (0..7).
REQ-018 SHIFT SHALL last min(8, CHAIN_LEN - bits_done) cycles and then go to EMIT; total scan_enable-high cycles per exchange SHALL equal exactly CHAIN_LEN.
REQ-019 EMIT: out_valid=1 and out_data=RX, held stable until out_ready; on out_valid&out_ready, SHALL go to LOAD if bits remain, else to DONE.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE.
REQ-021 Stream order SHALL be LSB-first; stream bit n is the nth bit shifted.
REQ-022 Partial last byte (CHAIN_LEN mod 8 != 0): unused upper bits of in_data SHALL be ignored, and the corresponding out_data upper bits SHALL be 0.
REQ-023 scan_enable SHALL be 0 outside SHIFT, so stalls in LOAD or EMIT never advance the chain.
REQ-024 proc_en SHALL be combinational: run & (state==IDLE) & ~start. The processor never executes during an exchange or on the start cycle.
REQ-025 The bit counter SHALL be at least 16 bits wide; no wrap-around is permitted within one exchange.
REQ-026 in_ready and out_valid SHALL never be high in the same cycle.

Reset
REQ-027 On rst=1 at a clock edge, state SHALL become IDLE, and TX, RX and the counter SHALL clear to 0.
REQ-028 After reset, busy, done, in_ready, out_valid, scan_enable, scan_out and proc_en SHALL be 0 and out_data SHALL be 0x00.
REQ-029 Reset mid-exchange SHALL abort with no done pulse; scan_enable SHALL be 0 from the next cycle.
REQ-030 rst SHALL take priority over start.

Verification
REQ-031 Reset: assert rst for 2 cycles with run=0 -> all outputs 0 and busy=0.
REQ-032 Exchange: CHAIN_LEN=12, model chain = 12-bit register preloaded 0xABC (out=reg[0], reg<={in,reg[11:1]}), feed 0x5A then 0x03 -> out bytes 0xBC then 0x0A, model holds 0x35A, exactly 12 scan_enable cycles, one done pulse.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in EMIT -> out_data stable, scan_enable=0, model contents unchanged.
REQ-034 Starvation: hold in_valid=0 for 7 cycles after start -> in_ready=1 throughout, scan_enable=0, busy=1.
REQ-035 Gating: run=1 idle gives proc_en=1; pulse start -> proc_en=0 that cycle and for the whole exchange; second start mid-exchange ignored; proc_en=1 the cycle after done.
REQ-036 Mid-shift reset: rst asserted on the 3rd SHIFT cycle -> scan_enable=0 next cycle, no done, next start begins a fresh 12-bit exchange.
